mem_port_arbiter: RTL and testbench

//  Shares the data side of the unified 64KB byte memory (load port + write port) between
//  two requesters: client 0 = pipeline load/store unit, client 1 = loader/DMA engine.
//  One access (16-bit big-endian word read or write) is issued per cycle. Read data is

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data-side load/write ports of the 64KB byte memory between
// client 0 (LSU) and client 1 (loader/DMA). Optional macro ARB_STARVE_EN adds a client-1 starvation guard.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [15:0] c0_addr,
  input  logic [15:0] c0_wdata,
  output logic        c0_gnt,
  output logic        c0_rvalid,
  output logic [15:0] c0_rdata,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [15:0] c1_addr,
  input  logic [15:0] c1_wdata,
  input  logic        c1_lock,
  output logic        c1_gnt,
  output logic        c1_rvalid,
  output logic [15:0] c1_rdata,
  output logic [15:0] mem_ldaddr,
  input  logic [15:0] mem_lddata,
  output logic        mem_wen,
  output logic [15:0] mem_waddr,
  output logic [15:0] mem_wdata,
  output logic        owner
);

  // state | meaning
  // ARB_IDLE  | fixed priority, client 0 first
  // ARB_LOCK1 | client 1 burst owns the port; client 0 blocked
  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_LOCK1 = 1'b1;

  logic        state;
  logic        state_nxt;
  logic        starve_hit;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  if (2**CNT_W <= STARVE_LIMIT) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold STARVE_LIMIT");
  end

`ifdef ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // counts cycles client 1 waits with a request up; the grant clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (c1_gnt) begin
      starve_cnt <= '0;
    end else if (c1_req && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    c0_gnt = 1'b0;
    c1_gnt = 1'b0;
    if (state == ARB_LOCK1) begin
      c1_gnt = c1_req;
    end else if (c1_req && starve_hit) begin
      c1_gnt = 1'b1;
    end else if (c0_req) begin
      c0_gnt = 1'b1;
    end else begin
      c1_gnt = c1_req;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (c1_gnt && c1_lock) state_nxt = ARB_LOCK1;
      default:   if (!c1_lock) state_nxt = ARB_IDLE;
    endcase
  end

  assign sel_we    = c1_gnt ? c1_we    : c0_we;
  assign sel_addr  = c1_gnt ? c1_addr  : c0_addr;
  assign sel_wdata = c1_gnt ? c1_wdata : c0_wdata;

  // idle memory buses are forced to zero so nothing downstream sees stale operands
  always_comb begin
    mem_ldaddr = 16'h0000;
    mem_wen    = 1'b0;
    mem_waddr  = 16'h0000;
    mem_wdata  = 16'h0000;
    if (c0_gnt || c1_gnt) begin
      if (sel_we) begin
        mem_wen   = 1'b1;
        mem_waddr = sel_addr;
        mem_wdata = sel_wdata;
      end else begin
        mem_ldaddr = sel_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= 1'b0;
      c0_rvalid <= 1'b0;
      c0_rdata  <= 16'h0000;
      c1_rvalid <= 1'b0;
      c1_rdata  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      c0_rvalid <= c0_gnt && !c0_we;
      c1_rvalid <= c1_gnt && !c1_we;
      if (c0_gnt && !c0_we) c0_rdata <= mem_lddata;
      if (c1_gnt && !c1_we) c1_rdata <= mem_lddata;
      if (c0_gnt || c1_gnt) owner <= c1_gnt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a byte-memory model and a per-cycle reference model
// of the arbitration rules; define ARB_STARVE_EN to exercise the starvation guard.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_req, c0_we, c0_gnt, c0_rvalid;
  logic [15:0] c0_addr, c0_wdata, c0_rdata;
  logic        c1_req, c1_we, c1_lock, c1_gnt, c1_rvalid;
  logic [15:0] c1_addr, c1_wdata, c1_rdata;
  logic [15:0] mem_ldaddr, mem_lddata, mem_waddr, mem_wdata;
  logic        mem_wen, owner;

  logic [7:0] mem    [0:65535];
  logic [7:0] shadow [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_lock(c1_lock), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .mem_ldaddr(mem_ldaddr), .mem_lddata(mem_lddata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .owner(owner)
  );

  always #5 clk = ~clk;

  assign mem_lddata = {mem[mem_ldaddr], mem[16'(mem_ldaddr + 16'd1)]};

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr]                  = mem_wdata[15:8];
      mem[16'(mem_waddr + 16'd1)]     = mem_wdata[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sh_word(input logic [15:0] a);
    return {shadow[a], shadow[16'(a + 16'd1)]};
  endfunction

  // reference model: winner chosen from the arbitration rules each cycle
  int          m_wait   = 0;
  bit          m_locked = 0;
  logic        e_rv0 = 0, e_rv1 = 0, e_owner = 0;
  logic [15:0] e_rd0 = 0, e_rd1 = 0;

  always @(negedge clk) begin
    int  win;
    bit  force1;
    if (reset) begin
      m_wait = 0; m_locked = 0;
      e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0; e_owner = 0;
    end
    chk("m_c0_rvalid", c0_rvalid, e_rv0);
    chk("m_c1_rvalid", c1_rvalid, e_rv1);
    chk("m_c0_rdata", c0_rdata, e_rd0);
    chk("m_c1_rdata", c1_rdata, e_rd1);
    chk("m_owner", owner, e_owner);
    if (!reset) begin
      force1 = 0;
`ifdef ARB_STARVE_EN
      force1 = (m_wait >= STARVE_LIMIT);
`endif
      if (m_locked)            win = c1_req ? 2 : 0;
      else if (c1_req && force1) win = 2;
      else if (c0_req)         win = 1;
      else if (c1_req)         win = 2;
      else                     win = 0;
      chk("m_c0_gnt", c0_gnt, win == 1);
      chk("m_c1_gnt", c1_gnt, win == 2);
      e_rv0 = 0; e_rv1 = 0;
      if (win == 0) begin
        chk("m_wen_idle", mem_wen, 0);
        chk("m_buses_idle", {mem_ldaddr, mem_waddr}, 0);
        chk("m_wdata_idle", mem_wdata, 0);
      end else begin
        logic        we;
        logic [15:0] a, d;
        we = (win == 1) ? c0_we : c1_we;
        a  = (win == 1) ? c0_addr : c1_addr;
        d  = (win == 1) ? c0_wdata : c1_wdata;
        chk("m_wen", mem_wen, we);
        if (we) begin
          chk("m_waddr", mem_waddr, a);
          chk("m_wdata", mem_wdata, d);
          shadow[a] = d[15:8];
          shadow[16'(a + 16'd1)] = d[7:0];
        end else begin
          chk("m_ldaddr", mem_ldaddr, a);
          if (win == 1) begin e_rv0 = 1; e_rd0 = sh_word(a); end
          else          begin e_rv1 = 1; e_rd1 = sh_word(a); end
        end
        e_owner = (win == 2);
      end
      if (win == 2)    m_wait = 0;
      else if (c1_req) m_wait++;
      m_locked = m_locked ? c1_lock : (win == 2 && c1_lock);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] b);
    mem[a] = b;
    shadow[a] = b;
  endtask

  task automatic drop_all();
    c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
    c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0; c1_lock = 0;
  endtask

  int first_c1;
  int exp_first;

  initial begin
    reset = 1;
    drop_all();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    preload(16'h0010, 8'hAB); preload(16'h0011, 8'hCD);
    preload(16'hFFFF, 8'h11); preload(16'h0000, 8'h22);

    @(negedge clk);
    chk("rst_c0_rvalid", c0_rvalid, 0);
    chk("rst_c0_rdata", c0_rdata, 16'h0000);
    chk("rst_owner", owner, 0);
    tick(); reset = 0;

    // plain client-0 read
    tick(); c0_req = 1; c0_we = 0; c0_addr = 16'h0010;
    @(negedge clk);
    chk("t1_gnt", c0_gnt, 1);
    tick(); c0_req = 0;
    @(negedge clk);
    chk("t1_rvalid", c0_rvalid, 1);
    chk("t1_rdata", c0_rdata, 16'hABCD);
    tick();
    @(negedge clk);
    chk("t1_rvalid_drop", c0_rvalid, 0);
    chk("t1_rdata_hold", c0_rdata, 16'hABCD);

    // contention: c0 write wins, c1 read sees the new data
    tick(); c0_req = 1; c0_we = 1; c0_addr = 16'h0020; c0_wdata = 16'h1234;
    c1_req = 1; c1_we = 0; c1_addr = 16'h0020;
    @(negedge clk);
    chk("t2_c0_first", {c0_gnt, c1_gnt}, 2'b10);
    tick(); c0_req = 0; c0_we = 0;
    @(negedge clk);
    chk("t2_c1_next", c1_gnt, 1);
    tick(); c1_req = 0;
    @(negedge clk);
    chk("t2_c1_rdata", c1_rdata, 16'h1234);
    chk("t2_owner", owner, 1);

    // locked client-1 burst with client 0 waiting
    tick(); c1_req = 1; c1_we = 1; c1_lock = 1; c1_addr = 16'h0100; c1_wdata = 16'h1111;
    @(negedge clk);
    chk("t3_beat0", c1_gnt, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      c0_req = 1; c0_we = 0; c0_addr = 16'h0010;
      c1_addr = 16'(16'h0100 + 2 * i);
      c1_wdata = 16'(16'h1111 * (i + 1));
      if (i == 3) c1_lock = 0;
      @(negedge clk);
      chk("t3_beat_c1", c1_gnt, 1);
      chk("t3_beat_c0_blocked", c0_gnt, 0);
    end
    tick(); c1_req = 0; c1_we = 0;
    @(negedge clk);
    chk("t3_c0_after_unlock", c0_gnt, 1);
    tick(); c0_addr = 16'h0103;
    @(negedge clk);
    chk("t3_c0_prev_rdata", c0_rdata, 16'hABCD);
    tick(); c0_req = 0;
    @(negedge clk);
    chk("t3_odd_rdata", c0_rdata, 16'h2233);

    // wrap at top of memory
    tick(); c1_req = 1; c1_we = 0; c1_addr = 16'hFFFF;
    @(negedge clk);
    chk("t4_gnt", c1_gnt, 1);
    tick(); c1_req = 0;
    @(negedge clk);
    chk("t4_wrap_rdata", c1_rdata, 16'h1122);

    // both held: starvation guard (or permanent starvation without it)
    first_c1 = 0;
    tick(); c0_req = 1; c0_we = 0; c0_addr = 16'h0010;
    c1_req = 1; c1_we = 0; c1_addr = 16'h0020;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (c1_gnt && first_c1 == 0) first_c1 = i;
      tick();
      if (first_c1 != 0) c1_req = 0;
    end
`ifdef ARB_STARVE_EN
    exp_first = 9;
`else
    exp_first = 0;
`endif
    chk("t5_first_c1_gnt_cycle", first_c1, exp_first);
    drop_all();

    // reset the cycle after a granted read
    tick(); c0_req = 1; c0_we = 0; c0_addr = 16'h0010;
    @(negedge clk);
    chk("t6_gnt", c0_gnt, 1);
    tick(); reset = 1; c0_req = 0;
    @(negedge clk);
    chk("t6_rvalid_dropped", c0_rvalid, 0);
    chk("t6_rdata_cleared", c0_rdata, 16'h0000);
    tick(); reset = 0;

    // reset releases a held lock
    tick(); c1_req = 1; c1_we = 0; c1_lock = 1; c1_addr = 16'h0010;
    @(negedge clk);
    chk("t6_lock_gnt", c1_gnt, 1);
    tick(); reset = 1; c1_req = 0;
    @(negedge clk);
    chk("t6_c1_rvalid_dropped", c1_rvalid, 0);
    tick(); reset = 0; c0_req = 1; c0_we = 0; c0_addr = 16'h0020;
    @(negedge clk);
    chk("t6_lock_released", c0_gnt, 1);
    tick(); drop_all();
    @(negedge clk);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
